// File: rtl/rf_writeback_queue.sv
// Register-file write-back merge queue: ALU and load producers feed one FIFO that
// retires one write per cycle and publishes a per-register pending bitmap.
module rf_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ADDR_W-1:0]       a_rd,
  input  logic [DATA_W-1:0]       a_data,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [ADDR_W-1:0]       m_rd,
  input  logic [DATA_W-1:0]       m_data,
  input  logic                    wb_hold,
  output logic                    we3,
  output logic [ADDR_W-1:0]       a3,
  output logic [DATA_W-1:0]       wd3,
  output logic [2**ADDR_W-1:0]    pending,
  output logic [$clog2(DEPTH):0]  count
);

  // Handshake: a request transfers on a rising edge where valid && ready;
  // rd/data must stay stable while valid is high and ready is low.

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**ADDR_W;
  localparam logic [CW:0] DEPTH_F = (CW+1)'(DEPTH);
  localparam logic [CW:0] TWO     = (CW+1)'(2);

  logic [ADDR_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     rd_ptr, wr_ptr;

  logic [ADDR_W-1:0] ent_rd_n [DEPTH];
  logic [DEPTH-1:0]  vld_n;
  logic [PW-1:0]     m_slot;
  logic [CW:0]       free;
  logic              pop, a_push, m_push;
  logic [NREG-1:0]   pending_n;

  assign pop  = (count != '0) && !wb_hold;
  assign free = DEPTH_F - {1'b0, count} + {{CW{1'b0}}, pop};

  // x0 requests are always accepted and simply dropped.
  assign a_ready = (a_rd == '0) || (free != '0);
  assign a_push  = a_valid && a_ready && (a_rd != '0);
  assign m_ready = (m_rd == '0) || (a_push ? (free >= TWO) : (free != '0));
  assign m_push  = m_valid && m_ready && (m_rd != '0);

  // ALU entry is always the older one when both push together.
  assign m_slot = wr_ptr + PW'(a_push);

  // Reset also masks the port so nothing reaches the register file that cycle.
  assign we3 = pop && !reset;
  assign a3  = (count != '0 && !reset) ? ent_rd[rd_ptr]   : '0;
  assign wd3 = (count != '0 && !reset) ? ent_data[rd_ptr] : '0;

  always_comb begin
    ent_rd_n = ent_rd;
    vld_n    = vld;
    if (pop)    vld_n[rd_ptr] = 1'b0;
    if (a_push) begin
      vld_n[wr_ptr]    = 1'b1;
      ent_rd_n[wr_ptr] = a_rd;
    end
    if (m_push) begin
      vld_n[m_slot]    = 1'b1;
      ent_rd_n[m_slot] = m_rd;
    end
  end

  always_comb begin
    pending_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_n[i]) pending_n[ent_rd_n[i]] = 1'b1;
    end
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      vld     <= '0;
      pending <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop);
      wr_ptr  <= wr_ptr + PW'(a_push) + PW'(m_push);
      count   <= count + CW'(a_push) + CW'(m_push) - CW'(pop);
      vld     <= vld_n;
      ent_rd  <= ent_rd_n;
      pending <= pending_n;
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) ent_data[wr_ptr] <= a_data;
    if (m_push) ent_data[m_slot] <= m_data;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Merges register-file write-back traffic from two producers into the register file's single write port (A3/WD3/WE3):
  - ALU result path (port a).
  - Load-data path (port m).
- Holds up to DEPTH pending writes and retires them strictly in acceptance order, one per cycle.
- Publishes a per-register pending bitmap so decode/hazard logic can stall reads of registers with writes still in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width (32 registers).
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- a_valid  input  1  ALU write request.
- a_ready  output  1  queue can accept an ALU request this cycle.
- a_rd  input  ADDR_W  ALU destination register.
- a_data  input  DATA_W  ALU write data.
- m_valid  input  1  load write request.
- m_ready  output  1  queue can accept a load request this cycle.
- m_rd  input  ADDR_W  load destination register.
- m_data  input  DATA_W  load write data.
- wb_hold  input  1  freezes retirement; no write is issued while high.
- we3  output  1  register-file write enable.
- a3  output  ADDR_W  register-file write address.
- wd3  output  DATA_W  register-file write data.
- pending  output  2**ADDR_W  bit r is set when any queued entry targets register r.
- count  output  clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
- Storage: circular buffer of DEPTH entries {rd, data}, with rd_ptr, wr_ptr and count.
  - Pointers wrap modulo DEPTH.
- Reset (synchronous, takes priority over everything):
  - rd_ptr=wr_ptr=0, count=0.
  - we3=0, a3=0, wd3=0, pending=0.
  - Entries in flight are discarded; nothing is written to the register file.
- Retire (pop):
  - Condition: count>0 and wb_hold=0.
  - we3=1, a3=head.rd, wd3=head.data, all driven combinationally from the head entry.
  - The pop takes effect at the next edge (rd_ptr+1).
  - Otherwise we3=0, and a3/wd3 still show the head, or 0 when empty.
- Accept handshake:
  - A request is accepted on an edge where valid&ready.
  - Data and rd must be held stable while valid=1 and ready=0.
- x0 requests:
  - A request with rd==0 is always ready.
  - It is accepted and dropped: never enqueued, never counted, never written.
- Free slots: free = DEPTH - count + (pop this cycle ? 1 : 0). Same-cycle pop frees a slot.
- a_ready = free>=1.
- m_ready:
  - free>=2 when an ALU push (non-x0) is accepted in the same cycle.
  - free>=1 otherwise.
- Ordering:
  - When both push in the same cycle, the ALU entry is enqueued first (older), then the load entry.
  - Retirement is strictly FIFO, which guarantees WAW order to the same register.
- count_next = count + pushes - pops, where pushes ∈ {0,1,2} and pops ∈ {0,1}.
  - The queue never overflows.
  - It never pops when empty (we3=0 when count=0).
- Latency: a request accepted at edge N, with an empty queue and no hold, appears on we3/a3/wd3 during cycle N+1 and is written at edge N+1.
- No bypass: a request is never written in its own acceptance cycle.
- pending:
  - Registered, recomputed every edge as the OR-decode of rd over all valid entries after that edge's push/pop.
  - pending[0] is always 0.
  - A register written twice stays pending until both entries retire.
- wb_hold:
  - Stops pops only.
  - Pushes continue until the queue is full; a_ready/m_ready then drop to 0.

Test Plan:
- Reset mid-operation: queue 3 entries, assert reset for 1 cycle → count=0, pending=0, we3=0 next cycle; none of the 3 writes ever appears.
- Single ALU push rd=5, data=0x0000_00F4 at edge N → cycle N+1: we3=1, a3=5, wd3=0xF4; pending[5]=1 after edge N, 0 after edge N+1.
- Simultaneous push ALU rd=3 data=0xC, load rd=3 data=0x1C into empty queue → retires (3,0xC) then (3,0x1C) on consecutive cycles; pending[3] clears only after the second.
- wb_hold=1 while pushing ALU every cycle with DEPTH=4 → count reaches 4, a_ready=0, we3=0; release hold → four writes in order on four consecutive cycles.
- count=3, hold=0, both push same cycle → a_ready=1, m_ready=1 (pop frees a slot), count stays 4; at count=4 with hold=1 both readies are 0.
- x0 push (a_rd=0, data=0xDEAD) → a_ready=1, count unchanged, we3 never asserted, pending unchanged.
